// File: rtl/alu_exec_stage_pkg.sv
// Shared ALU execute-stage definitions: opcode mnemonics and the flag bundle.
// Latency: none (type and constant definitions only).
// Backpressure: not applicable.
package definitions;

  // Opcode encoding presented on in_op.
  typedef enum logic [2:0] {
    kADD = 3'd0,
    kSUB = 3'd1,
    kLSH = 3'd2,
    kRSH = 3'd3,
    kXOR = 3'd4,
    kORR = 3'd5,
    kCLR = 3'd6,
    kRXR = 3'd7
  } op_mne;

  // Result flags produced alongside every ALU result.
  typedef struct packed {
    logic carry;  // carry out for ADD, no-borrow for SUB, 0 otherwise
    logic zero;   // result == 0
  } flags_t;

endpackage

// File: rtl/alu_exec_stage_alu_core.sv
// Combinational ALU evaluation between the operand and result registers.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the enclosing stage decides when the result is captured.
// Ports: op/a/b operation in; result, carry, zero out.
module alu_core
  import definitions::*;
#(
  parameter int W = 8
) (
  input  op_mne        op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         carry,
  output logic         zero
);

  // One extra bit so the adder's carry-out falls out of the sum directly.
  logic [W:0] sum;
  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    unique case (op)
      kADD: begin
        result = sum[W-1:0];
        carry  = sum[W];
      end
      kSUB: begin
        result = a - b;
        carry  = (a >= b);  // no-borrow sense: 1 when A >= B unsigned
      end
      kLSH: result = a << b[2:0];
      kRSH: result = a >> b[2:0];
      kXOR: result = a ^ b;
      kORR: result = a | b;
      kCLR: result = '0;
      kRXR: result = {{(W-1){1'b0}}, ^a};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_exec_stage.sv
// Two-stage ALU execute pipeline: operand register (S1), ALU, result register (S2).
// Latency: op accepted at edge N has out_valid=1 after edge N+1; one op/cycle sustained.
// Backpressure: out_ready=0 fills S2 then S1; in_ready drops only when S1 cannot advance.
// Ports: Clk/Reset_n; in_valid/in_ready/in_op/in_a/in_b upstream;
//        out_valid/out_ready/out_result (+ out_carry/out_zero) downstream.
// Build option: define ALU_FLAGS_EN to add the out_carry/out_zero flag outputs.
module alu_exec_stage
  import definitions::*;
#(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  op_mne        in_op,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result
`ifdef ALU_FLAGS_EN
  ,
  output logic         out_carry,
  output logic         out_zero
`endif
);

  // S1: captured operation.
  logic         s1_valid;
  op_mne        s1_op;
  logic [W-1:0] s1_a;
  logic [W-1:0] s1_b;

  // S2: captured result.
  logic         s2_valid;
  logic [W-1:0] s2_result;

  // ALU outputs.
  logic [W-1:0] core_result;
  flags_t       core_flags;

  logic accept;
  logic s2_load;

  // S2 takes S1 whenever S2 is empty or its current content leaves this cycle.
  assign s2_load  = s1_valid && (!s2_valid || out_ready);
  // S1 is free if empty or draining into S2; depends on out_ready, never on in_valid.
  assign in_ready = !s1_valid || s2_load;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid <= 1'b0;
      s1_op    <= kADD;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_op    <= in_op;
      s1_a     <= in_a;
      s1_b     <= in_b;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  alu_core #(.W(W)) u_alu_core (
    .op     (s1_op),
    .a      (s1_a),
    .b      (s1_b),
    .result (core_result),
    .carry  (core_flags.carry),
    .zero   (core_flags.zero)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
    end else if (s2_load) begin
      s2_valid  <= 1'b1;
      s2_result <= core_result;
    end else if (out_ready) begin
      s2_valid  <= 1'b0;  // consumed with nothing behind it
    end
  end

  assign out_valid  = s2_valid;
  assign out_result = s2_result;

`ifdef ALU_FLAGS_EN
  flags_t s2_flags;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s2_flags <= '0;
    end else if (s2_load) begin
      s2_flags <= core_flags;
    end
  end

  assign out_carry = s2_flags.carry;
  assign out_zero  = s2_flags.zero;
`else
  // Flags are still computed by the shared core but go nowhere in this build.
  flags_t flags_unused;
  assign flags_unused = core_flags;
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed self-checking bench for alu_exec_stage (W=8).
// Latency: inputs driven 1 ns after a rising edge, outputs sampled 1 ns after an edge.
// Backpressure: exercised by holding out_ready low with a stream of ops.
module tb_alu_exec_stage;
  import definitions::*;

  localparam int W = 8;

  logic         Clk;
  logic         Reset_n;
  logic         in_valid;
  logic         in_ready;
  op_mne        in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
`ifdef ALU_FLAGS_EN
  logic         out_carry;
  logic         out_zero;
`endif

  int errors = 0;
  int checks = 0;

  alu_exec_stage #(.W(W)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
`ifdef ALU_FLAGS_EN
    ,
    .out_carry  (out_carry),
    .out_zero   (out_zero)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Push one op with out_ready=1 and check it appears exactly one edge after acceptance.
  task automatic run_op(input string tag, input op_mne op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp_res,
                        input logic exp_c, input logic exp_z);
    in_valid  = 1'b1;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    out_ready = 1'b1;
    check({tag, ".in_ready"}, in_ready, 1);
    tick();
    // Garbage on the operand bus once in_valid is low must be ignored.
    in_valid = 1'b0;
    in_op    = kCLR;
    in_a     = 8'hA5;
    in_b     = 8'h5A;
    check({tag, ".lat1_valid"}, out_valid, 0);
    tick();
    check({tag, ".valid"}, out_valid, 1);
    check({tag, ".result"}, out_result, exp_res);
`ifdef ALU_FLAGS_EN
    check({tag, ".carry"}, out_carry, exp_c);
    check({tag, ".zero"}, out_zero, exp_z);
`else
    if (exp_c === 1'bx || exp_z === 1'bx) $display("note: unknown flag expectation in %s", tag);
`endif
    tick();
    check({tag, ".drained"}, out_valid, 0);
  endtask

  initial begin
    Reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_op     = kADD;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;

    // Reset state, including in_ready=1 while held in reset.
    #12;
    check("rst.out_valid", out_valid, 0);
    check("rst.out_result", out_result, 0);
    check("rst.in_ready", in_ready, 1);
    @(negedge Clk);
    Reset_n = 1'b1;
    tick();

    // Arithmetic and logic vectors.
    run_op("add_f0_20", kADD, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0);
    run_op("sub_05_07", kSUB, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0);
    run_op("sub_07_07", kSUB, 8'h07, 8'h07, 8'h00, 1'b1, 1'b1);
    run_op("lsh_81_3",  kLSH, 8'h81, 8'h03, 8'h08, 1'b0, 1'b0);
    run_op("rsh_81_7",  kRSH, 8'h81, 8'h07, 8'h01, 1'b0, 1'b0);
    run_op("lsh_81_b9", kLSH, 8'h81, 8'h09, 8'h02, 1'b0, 1'b0);
    run_op("rxr_07",    kRXR, 8'h07, 8'h00, 8'h01, 1'b0, 1'b0);
    run_op("rxr_03",    kRXR, 8'h03, 8'hFF, 8'h00, 1'b0, 1'b1);
    run_op("clr",       kCLR, 8'h3C, 8'hC3, 8'h00, 1'b0, 1'b1);
    run_op("xor",       kXOR, 8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b0);
    run_op("orr",       kORR, 8'h50, 8'h05, 8'h55, 1'b0, 1'b0);
    run_op("add_ff_01", kADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1);

    // Backpressure: four ADD x+0 ops with out_ready low.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = kADD;
    in_b      = 8'h00;
    in_a      = 8'h01;
    check("bp.rdy_empty", in_ready, 1);
    tick();                       // op1 -> S1
    in_a = 8'h02;
    check("bp.rdy_s1", in_ready, 1);
    tick();                       // op1 -> S2, op2 -> S1
    in_a = 8'h03;
    check("bp.full_valid", out_valid, 1);
    check("bp.full_res", out_result, 8'h01);
    check("bp.rdy_full", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp.hold_res", out_result, 8'h01);
      check("bp.hold_rdy", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    check("bp.rdy_release", in_ready, 1);
    tick();                       // op1 consumed, op2 -> S2, op3 -> S1
    in_a = 8'h04;
    check("bp.res2", out_result, 8'h02);
    check("bp.val2", out_valid, 1);
    tick();                       // op3 -> S2, op4 -> S1
    in_valid = 1'b0;
    check("bp.res3", out_result, 8'h03);
    tick();
    check("bp.res4", out_result, 8'h04);
    check("bp.val4", out_valid, 1);
    tick();
    check("bp.empty", out_valid, 0);

    // Streaming: 10 back-to-back ops, out_valid high for 10 cycles after one of latency.
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i < 10) begin
        in_valid = 1'b1;
        in_op    = kADD;
        in_a     = 8'(i + 16);
        in_b     = 8'h00;
        check("st.in_ready", in_ready, 1);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i == 0) begin
        check("st.first_lat", out_valid, 0);
      end else if (i <= 10) begin
        check("st.valid", out_valid, 1);
        check("st.result", out_result, 32'(i - 1 + 16));
      end else begin
        check("st.done", out_valid, 0);
      end
    end

    // Reset with two ops in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = kADD;
    in_a      = 8'h05;
    in_b      = 8'h05;
    tick();
    in_a = 8'h06;
    tick();
    in_valid = 1'b0;
    check("rr.pre_valid", out_valid, 1);
    check("rr.pre_res", out_result, 8'h0A);
    #2;
    Reset_n = 1'b0;
    #1;
    check("rr.valid", out_valid, 0);
    check("rr.result", out_result, 0);
    check("rr.in_ready", in_ready, 1);
    tick();
    @(negedge Clk);
    Reset_n   = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rr.no_stale", out_valid, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
